imem_loader: RTL and testbench

- Writer side of instruction memory: receives a program as a byte stream with a valid/ready handshake.
- Packs each 4 bytes into a 32-bit big-endian word and issues one write per word to the IM write port.
- Writes start at byte address IM_BASE (0x0000_3000) and step by 4.
- Sits between the host/UART byte source and the IM, and loads code before the CPU is released from reset.

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_loader_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 109 ++++++++++
 tb/tb_imem_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam int          IMSIZE     = 4096;
  localparam int          CNT_W      = 13;
  localparam bit          BIG_ENDIAN = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four accepted bytes into one 32-bit word, first byte in the MSBs.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);
  logic [1:0]  idx_q;
  logic [31:0] word_q;
  logic [31:0] word_shifted;

  generate
    if (BIG_ENDIAN) begin : g_be
      assign word_shifted = {word_q[23:0], byte_in};
    end else begin : g_le
      assign word_shifted = {byte_in, word_q[31:8]};
    end
  endgenerate

  // The index wraps to 0 on the fourth byte, so each word starts clean.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (byte_en) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= word_shifted;
    end
  end

  assign word_out  = word_q;
  assign word_full = byte_en && (idx_q == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wise program into instruction memory, one write per 4 bytes.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      checksum
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      csum_q, csum_d;
  logic             err_q, err_d;
  logic             pack_clr;
  logic             byte_en;
  logic             word_full;
  logic [31:0]      word;

  assign in_ready = (state_q == S_COLLECT);
  assign im_we    = (state_q == S_WRITE);
  assign busy     = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign done     = (state_q == S_FINISH);
  assign err      = err_q;
  assign checksum = csum_q;
  assign im_addr  = addr_q;
  assign im_wdata = word;
  assign byte_en  = in_valid && in_ready;

  imem_loader_byte_packer u_byte_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pack_clr),
    .byte_en   (byte_en),
    .byte_in   (in_data),
    .word_out  (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    csum_d   = csum_q;
    err_d    = err_q;
    pack_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pack_clr = 1'b1;
          err_d    = 1'b0;
          csum_d   = 32'd0;
          count_d  = word_count;
          cnt_d    = '0;
          addr_d   = IM_BASE;
          if (word_count == '0) begin
            state_d = S_FINISH;
          end else if (word_count > CNT_W'(IMSIZE)) begin
            // Oversized request is refused outright; nothing is written.
            err_d = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (word_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        csum_d  = csum_q ^ word;
        cnt_d   = cnt_q + CNT_W'(1);
        addr_d  = addr_q + 32'd4;
        state_d = (cnt_d == count_q) ? S_FINISH : S_COLLECT;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      cnt_q   <= '0;
      addr_q  <= IM_BASE;
      csum_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] wr_addr [0:4199];
  logic [31:0] wr_data [0:4199];
  int n_wr = 0;
  int n_done = 0;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (im_we) begin
      if (n_wr < 4200) begin
        wr_addr[n_wr] = im_addr;
        wr_data[n_wr] = im_wdata;
      end
      n_wr++;
    end
    if (done) n_done++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    n_wr   = 0;
    n_done = 0;
  endtask

  task automatic pulse_start(input logic [12:0] wc, output int scyc);
    word_count = wc;
    start      = 1'b1;
    scyc       = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int tries;
    acc      = 1'b0;
    tries    = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && tries < 50) begin
      acc = in_ready;
      tick();
      tries++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < max && !ok; i++) begin
      if (done) begin
        ok = 1'b1;
        at = cyc;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; word_count = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, im_we, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000", {in_ready, im_we, busy, done, err});
    end
    checks++;
    if (im_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL reset_addr: got %h required 00003000", im_addr);
    end
    checks++;
    if (im_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_wdata: got %h required 00000000", im_wdata);
    end
    checks++;
    if (checksum !== 32'h0) begin
      errors++; $display("FAIL reset_checksum: got %h required 00000000", checksum);
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic_load();
    int s, at; bit ok;
    logic [7:0] bytes [8];
    bytes = '{8'h34, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C};
    clear_log();
    pulse_start(13'd2, s);
    for (int i = 0; i < 8; i++) send_byte(bytes[i]);
    wait_done(20, ok, at);
    checks++;
    if (!ok || (at - s) != 11) begin
      errors++; $display("FAIL basic_done_latency: got ok=%0d latency=%0d required ok=1 latency=11", ok, at - s);
    end
    checks++;
    if (checksum !== 32'h3408000D) begin
      errors++; $display("FAIL basic_checksum: got %h required 3408000d", checksum);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: got busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (n_wr != 2) begin
      errors++; $display("FAIL basic_write_count: got %0d required 2", n_wr);
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h3000 || wr_data[0] !== 32'h34080001) begin
        errors++; $display("FAIL basic_write0: got %h:%h required 00003000:34080001", wr_addr[0], wr_data[0]);
      end
      checks++;
      if (wr_addr[1] !== 32'h3004 || wr_data[1] !== 32'h0000000C) begin
        errors++; $display("FAIL basic_write1: got %h:%h required 00003004:0000000c", wr_addr[1], wr_data[1]);
      end
    end
    $display("test_basic_load: writes=%0d checksum=%h", n_wr, checksum);
  endtask

  task automatic test_throttled();
    int s, at, bad; bit ok;
    logic [7:0] bytes [4];
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_log();
    bad = 0;
    pulse_start(13'd1, s);
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        in_valid = 1'b1; in_data = bytes[i / 2];
      end else begin
        in_valid = 1'b0; in_data = 8'h55;
      end
      if (in_ready !== 1'b1) bad++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL throttle_ready: got %0d cycles with in_ready low required 0", bad);
    end
    wait_done(20, ok, at);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL throttle_done: got no done required done");
    end
    tick();
    checks++;
    if (n_wr != 1 || wr_addr[0] !== 32'h3000 || wr_data[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL throttle_write: got n=%0d %h:%h required n=1 00003000:deadbeef", n_wr, wr_addr[0], wr_data[0]);
    end
    $display("test_throttled: writes=%0d", n_wr);
  endtask

  task automatic test_degenerate();
    int s, at; bit ok;
    clear_log();
    pulse_start(13'd0, s);
    wait_done(5, ok, at);
    checks++;
    if (!ok || (at - s) != 1 || err !== 1'b0) begin
      errors++; $display("FAIL zero_count: got ok=%0d latency=%0d err=%b required 1 1 0", ok, at - s, err);
    end
    tick();
    clear_log();
    pulse_start(13'd4097, s);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL oversize_err: got err=%b busy=%b required 1 0", err, busy);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (err !== 1'b1 || n_done != 0 || n_wr != 0) begin
      errors++; $display("FAIL oversize_sticky: got err=%b done=%0d wr=%0d required 1 0 0", err, n_done, n_wr);
    end
    pulse_start(13'd1, s);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL oversize_clear: got err=%b required 0", err);
    end
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    wait_done(10, ok, at);
    tick();
    checks++;
    if (!ok || n_wr != 1 || wr_data[0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL recover_load: got ok=%0d n=%0d data=%h required 1 1 cafef00d", ok, n_wr, wr_data[0]);
    end
    $display("test_degenerate: done");
  endtask

  task automatic test_reset_mid_word();
    int s;
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clear_log();
    pulse_start(13'd3, s);
    for (int i = 0; i < 6; i++) send_byte(bytes[i]);
    reset = 1'b1;
    tick();
    checks++;
    if ({in_ready, im_we, busy, done, err} !== 5'b0 || im_addr !== 32'h3000 ||
        im_wdata !== 32'h0 || checksum !== 32'h0) begin
      errors++; $display("FAIL midreset_outputs: got flags=%b addr=%h wdata=%h csum=%h required 00000 00003000 0 0",
                         {in_ready, im_we, busy, done, err}, im_addr, im_wdata, checksum);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (n_wr != 1 || wr_addr[0] !== 32'h3000 || wr_data[0] !== 32'h11223344 || n_done != 0) begin
      errors++; $display("FAIL midreset_writes: got n=%0d %h:%h done=%0d required 1 00003000:11223344 0",
                         n_wr, wr_addr[0], wr_data[0], n_done);
    end
    $display("test_reset_mid_word: writes=%0d", n_wr);
  endtask

  task automatic test_start_while_busy();
    int s, at; bit ok;
    clear_log();
    pulse_start(13'd2, s);
    send_byte(8'h01); send_byte(8'h02);
    word_count = 13'd5; start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hA0); send_byte(8'hB0); send_byte(8'hC0); send_byte(8'hD0);
    wait_done(30, ok, at);
    checks++;
    if (!ok || checksum !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL busy_start_done: got ok=%0d csum=%h required 1 a1b2c3d4", ok, checksum);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (n_wr != 2 || n_done != 1 || wr_addr[1] !== 32'h3004 || wr_data[1] !== 32'hA0B0C0D0 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_ignored: got n=%0d done=%0d %h:%h busy=%b required 2 1 00003004:a0b0c0d0 0",
                         n_wr, n_done, wr_addr[1], wr_data[1], busy);
    end
    $display("test_start_while_busy: writes=%0d", n_wr);
  endtask

  task automatic test_full_capacity();
    int s, at, bad; bit ok;
    logic [31:0] maxa;
    clear_log();
    pulse_start(13'd4096, s);
    for (int w = 0; w < 4096; w++) begin
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'(w >> 8)); send_byte(8'(w));
    end
    wait_done(20, ok, at);
    tick(); tick();
    checks++;
    if (!ok || n_wr != 4096) begin
      errors++; $display("FAIL full_count: got ok=%0d n=%0d required 1 4096", ok, n_wr);
    end else begin
      bad = 0; maxa = 32'h0;
      for (int i = 0; i < 4096; i++) begin
        if (wr_addr[i] !== 32'h3000 + 32'(4 * i) || wr_data[i] !== 32'(i)) bad++;
        if (wr_addr[i] > maxa) maxa = wr_addr[i];
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL full_data: got %0d bad writes required 0", bad);
      end
      checks++;
      if (wr_addr[4095] !== 32'h6FFC || maxa !== 32'h6FFC) begin
        errors++; $display("FAIL full_last_addr: got last=%h max=%h required 00006ffc", wr_addr[4095], maxa);
      end
    end
    checks++;
    if (checksum !== 32'h0) begin
      errors++; $display("FAIL full_checksum: got %h required 00000000", checksum);
    end
    $display("test_full_capacity: writes=%0d", n_wr);
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_throttled();
    test_degenerate();
    test_reset_mid_word();
    test_start_while_busy();
    test_full_capacity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
